// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  // Fixed byte-enable used for every instruction fetch
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory bus between instruction fetch and
// load/store. MEM has fixed priority. One transaction is in flight at a time,
// branch flushes kill in-flight fetches, and hung transactions time out.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_done_o,
  output logic        if_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        mem_stall_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

  arb_state_e       r_state;
  arb_owner_e       r_owner;
  logic             r_req;
  logic             r_we;
  logic [3:0]       r_be;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_kill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_if_done;
  logic             r_mem_done;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_mem_rdata;
  logic             r_err;

  logic             w_timeout;
  logic             w_kill;
  logic             w_finish;
  logic             w_fin_err;
  logic [31:0]      w_fin_data;

  // Completion decision: rvalid or timeout ends the wait; a same-cycle flush
  // already counts as kill so the fetch data is discarded.
  always_comb begin
    w_timeout  = TIMEOUT_EN && (r_cnt == CNT_LIMIT);
    w_kill     = r_kill | (flush_i & (r_owner == OWN_IF) & (r_state != IDLE));
    w_finish   = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_data = '0;
    case (r_state)
      REQ: begin
        if (!bus_gnt_i && w_timeout) begin
          w_finish  = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      RESP: begin
        if (bus_rvalid_i) begin
          w_finish   = 1'b1;
          w_fin_data = bus_rdata_i;
        end else if (w_timeout) begin
          w_finish  = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request/grant/response sequencer with latched bus fields and done pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_kill      <= 1'b0;
      r_cnt       <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_err      <= 1'b0;
      if (r_state != IDLE) r_kill <= w_kill;
      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (mem_req_i) begin
            r_owner <= OWN_MEM;
            r_we    <= mem_we_i;
            r_be    <= mem_be_i;
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= REQ;
          end else if (if_req_i) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= FETCH_BE;
            r_addr  <= if_addr_i;
            r_wdata <= '0;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RESP;
          end else if (!w_timeout && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (!bus_rvalid_i && !w_timeout && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          r_kill  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Finish overrides the per-state updates above
      if (w_finish) begin
        r_state <= DONE;
        r_req   <= 1'b0;
        r_err   <= w_fin_err;
        if (r_owner == OWN_MEM) begin
          r_mem_done  <= 1'b1;
          r_mem_rdata <= w_fin_data;
        end else if (!w_kill) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= w_fin_data;
        end
      end
    end
  end

  assign bus_req_o   = r_req;
  assign bus_we_o    = r_we;
  assign bus_be_o    = r_be;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign bus_err_o   = r_err;
  assign mem_done_o  = r_mem_done;
  assign mem_rdata_o = r_mem_rdata;
  assign if_rdata_o  = r_if_rdata;
  // A flush landing in the DONE cycle still has to hide the fetch completion
  assign if_done_o   = r_if_done & ~flush_i;
  assign if_stall_o  = if_req_i & ~if_done_o;
  assign mem_stall_o = mem_req_i & ~mem_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a short timeout.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_done_o;
  logic        if_stall_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        mem_stall_o;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  mem_port_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .mem_stall_o(mem_stall_o),
    .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every completion pulse is matched against the oldest expected transaction
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i === 1'b1 && (if_done_o === 1'b1 || mem_done_o === 1'b1)) begin
      chk("done_exclusive", {31'b0, if_done_o & mem_done_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'b0, if_done_o, mem_done_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_mem_done", {31'b0, mem_done_o}, {31'b0, e.is_mem});
        chk("sb_if_done", {31'b0, if_done_o}, {31'b0, !e.is_mem});
        chk("sb_rdata", e.is_mem ? mem_rdata_o : if_rdata_o, e.data);
        chk("sb_err", {31'b0, bus_err_o}, {31'b0, e.err});
      end
    end
  end

  // Bus slave for one transaction; returns at the negedge of the DONE cycle
  task automatic serve(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input int gnt_wait, input int rv_wait,
                       input logic [31:0] rd, input bit flush_resp);
    int n = 0;
    while (bus_req_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("bus_req_seen", {31'b0, bus_req_o}, 32'd1);
    for (int i = 0; i <= gnt_wait; i++) begin
      if (i > 0) @(negedge clk_i);
      chk("req_held", {31'b0, bus_req_o}, 32'd1);
      chk("bus_addr", bus_addr_o, a);
      chk("bus_we", {31'b0, bus_we_o}, {31'b0, we});
      chk("bus_be", {28'b0, bus_be_o}, {28'b0, be});
      chk("bus_wdata", bus_wdata_o, wd);
    end
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    chk("req_drop", {31'b0, bus_req_o}, 32'd0);
    if (flush_resp) flush_i = 1'b1;
    for (int i = 0; i < rv_wait; i++) begin
      @(negedge clk_i);
      flush_i = 1'b0;
    end
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rd;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_be_i = 4'hF; mem_addr_i = '0; mem_wdata_i = '0; flush_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be_o}, 32'd0);
    chk("rst_dones", {30'b0, if_done_o, mem_done_o}, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // MEM read alone, best-case timing
    mem_req_i = 1'b1; mem_addr_i = 32'h100;
    sb.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    @(negedge clk_i);
    chk("t1_req", {31'b0, bus_req_o}, 32'd1);
    chk("t1_addr", bus_addr_o, 32'h100);
    chk("t1_stall", {31'b0, mem_stall_o}, 32'd1);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    chk("t2_req_drop", {31'b0, bus_req_o}, 32'd0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    chk("t3_mem_done", {31'b0, mem_done_o}, 32'd1);
    chk("t3_mem_rdata", mem_rdata_o, 32'hDEADBEEF);
    chk("t3_if_done", {31'b0, if_done_o}, 32'd0);
    chk("t3_stall_clr", {31'b0, mem_stall_o}, 32'd0);
    mem_req_i = 1'b0;
    @(negedge clk_i);

    // Simultaneous requests: MEM first, IF after MEM's DONE
    if_req_i = 1'b1; if_addr_i = 32'h200; mem_req_i = 1'b1; mem_addr_i = 32'h300;
    sb.push_back('{1'b1, 32'h11110000, 1'b0});
    sb.push_back('{1'b0, 32'h22220000, 1'b0});
    serve(32'h300, 1'b0, 4'hF, 32'h0, 1, 1, 32'h11110000, 1'b0);
    chk("sim_if_stall", {31'b0, if_stall_o}, 32'd1);
    mem_req_i = 1'b0;
    @(negedge clk_i);
    chk("sim_if_stall_idle", {31'b0, if_stall_o}, 32'd1);
    serve(32'h200, 1'b0, 4'hF, 32'h0, 0, 0, 32'h22220000, 1'b0);
    chk("sim_if_done", {31'b0, if_done_o}, 32'd1);
    if_req_i = 1'b0;
    @(negedge clk_i);

    // Store with delayed grant
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_be_i = 4'b0011;
    mem_addr_i = 32'h400; mem_wdata_i = 32'h1234;
    sb.push_back('{1'b1, 32'h55, 1'b0});
    serve(32'h400, 1'b1, 4'b0011, 32'h1234, 3, 0, 32'h55, 1'b0);
    chk("st_done", {31'b0, mem_done_o}, 32'd1);
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_be_i = 4'hF; mem_wdata_i = '0;
    @(negedge clk_i);

    // Flush during IF RESP, then a fresh fetch
    if_req_i = 1'b1; if_addr_i = 32'h500;
    serve(32'h500, 1'b0, 4'hF, 32'h0, 0, 2, 32'hAAAA, 1'b1);
    chk("fl_no_done", {31'b0, if_done_o}, 32'd0);
    if_req_i = 1'b0;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h504;
    sb.push_back('{1'b0, 32'hBBBB, 1'b0});
    serve(32'h504, 1'b0, 4'hF, 32'h0, 0, 0, 32'hBBBB, 1'b0);
    chk("fl_next_done", {31'b0, if_done_o}, 32'd1);
    if_req_i = 1'b0;
    @(negedge clk_i);

    // Timeout: counter 0..4 in REQ, fires when it equals 4 -> 5 cycles of req
    mem_req_i = 1'b1; mem_addr_i = 32'h600;
    sb.push_back('{1'b1, 32'h0, 1'b1});
    cnt = 0;
    while (bus_req_o !== 1'b1 && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    cnt = 0;
    while (bus_req_o === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("to_req_cycles", cnt, 32'd5);
    chk("to_err", {31'b0, bus_err_o}, 32'd1);
    chk("to_done", {31'b0, mem_done_o}, 32'd1);
    chk("to_rdata", mem_rdata_o, 32'd0);
    mem_req_i = 1'b0;
    @(negedge clk_i);
    chk("to_err_pulse", {31'b0, bus_err_o}, 32'd0);

    // Async reset while in RESP
    if_req_i = 1'b1; if_addr_i = 32'h700;
    @(negedge clk_i);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("ar_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("ar_bus_addr", bus_addr_o, 32'd0);
    chk("ar_done_err", {29'b0, if_done_o, mem_done_o, bus_err_o}, 32'd0);
    if_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    mem_req_i = 1'b1; mem_addr_i = 32'h800;
    sb.push_back('{1'b1, 32'hC0FFEE, 1'b0});
    serve(32'h800, 1'b0, 4'hF, 32'h0, 0, 0, 32'hC0FFEE, 1'b0);
    chk("ar_after_done", {31'b0, mem_done_o}, 32'd1);
    mem_req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
